// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: control FSM state encoding.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/F_adder.sv
// One-bit full-adder cell, purely combinational.
module F_adder (
    output logic S,
    output logic Cout,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands fed LSB-first through one full-adder cell,
// sum gathered in a shift register and published in parallel with cout on done.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    import serial_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] aSh;
    logic [WIDTH-1:0] bSh;
    logic [WIDTH-1:0] sumSh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             cellSum;
    logic             cellCarry;

    F_adder uCell (
        .S    (cellSum),
        .Cout (cellCarry),
        .A    (aSh[0]),
        .B    (bSh[0]),
        .Cin  (carry)
    );

    // Control FSM with datapath; sum/cout only change on the last shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            aSh   <= '0;
            bSh   <= '0;
            sumSh <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        aSh   <= a;
                        bSh   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sumSh <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sumSh <= {cellSum, sumSh[WIDTH-1:1]};
                    carry <= cellCarry;
                    aSh   <= aSh >> 1;
                    bSh   <= bSh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum   <= {cellSum, sumSh[WIDTH-1:1]};
                        cout  <= cellCarry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=4 instances) against a+b+cin.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;
    int doneCnt4 = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (done4 === 1'b1) doneCnt4 <= doneCnt4 + 1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    // Reference: exact (WIDTH+1)-bit sum.
    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return 9'(t);
    endfunction

    function automatic logic [4:0] ref4(input int unsigned x, input int unsigned y, input int unsigned c);
        return 5'(x + y + c);
    endfunction

    // Issue one add on the 8-bit unit; lat = edges after the accepting edge until done seen, -1 on timeout.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c,
                        output logic [8:0] res, output int lat);
        start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin lat = k; break; end
        end
        res = {cout8, sum8};
    endtask

    task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic c,
                        output logic [4:0] res, output int lat);
        start4 = 1'b1; a4 = x; b4 = y; cin4 = c;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) begin lat = k; break; end
        end
        res = {cout4, sum4};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b cout=%b sum=%h expected all 0",
                     busy8, done8, cout8, sum8);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle got busy=%b done=%b expected 0 0", busy8, done8);
            end
        end
    endtask

    task automatic test_basic;
        int busyCnt;
        int lat;
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        busyCnt = 0;
        lat = -1;
        for (int k = 0; k <= 40; k++) begin
            if (done8 === 1'b1) begin lat = k; break; end
            if (busy8 === 1'b1) busyCnt++;
            if (sum8 !== 8'h00) begin
                checks++; errors++;
                $display("FAIL basic_sum_held got %h expected 00 during shift", sum8);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency got %0d expected 8", lat);
        end
        checks++;
        if (busyCnt != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d expected 8", busyCnt);
        end
        checks++;
        if ({cout8, sum8} !== ref8(8'h5A, 8'h3C, 1'b0) || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got cout=%b sum=%h busy=%b expected cout=0 sum=96 busy=0",
                     cout8, sum8, busy8);
        end
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b0 || sum8 !== 8'h96 || cout8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b sum=%h cout=%b expected done=0 sum=96 cout=0",
                     done8, sum8, cout8);
        end
    endtask

    task automatic test_edge_values;
        logic [8:0] res;
        int lat;
        run8(8'hFF, 8'h01, 1'b0, res, lat);
        checks++;
        if (res !== 9'h100 || lat != 8) begin
            errors++;
            $display("FAIL edge_ff_01 got %h lat %0d expected 100 lat 8", res, lat);
        end
        run8(8'hFF, 8'hFF, 1'b1, res, lat);
        checks++;
        if (res !== 9'h1FF || lat != 8) begin
            errors++;
            $display("FAIL edge_ff_ff_1 got %h lat %0d expected 1ff lat 8", res, lat);
        end
    endtask

    task automatic test_ignore_busy;
        int lat;
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin lat = k; break; end
            if (k == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; end
            if (k == 4) start8 = 1'b0;
        end
        checks++;
        if ({cout8, sum8} !== ref8(8'h05, 8'h03, 1'b0) || lat != 8) begin
            errors++;
            $display("FAIL ignore_busy got cout=%b sum=%h lat %0d expected cout=0 sum=08 lat 8",
                     cout8, sum8, lat);
        end
        @(posedge clk); #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_idle got busy=%b done=%b expected 0 0", busy8, done8);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] pa1, pb1, pa2, pb2;
        logic       pc1, pc2;
        logic [8:0] r1, r2;
        int t1, t2;
        pa1 = 8'($urandom); pb1 = 8'($urandom); pc1 = 1'($urandom);
        pa2 = 8'($urandom); pb2 = 8'($urandom); pc2 = 1'($urandom);
        start8 = 1'b1; a8 = pa1; b8 = pb1; cin8 = pc1;
        @(posedge clk); #1;
        a8 = pa2; b8 = pb2; cin8 = pc2;
        t1 = -1; r1 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin t1 = k; r1 = {cout8, sum8}; break; end
        end
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b done=%b expected 1 0", busy8, done8);
        end
        t2 = -1; r2 = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin t2 = k + 1; r2 = {cout8, sum8}; break; end
        end
        checks++;
        if (r1 !== ref8(pa1, pb1, pc1) || t1 != 8) begin
            errors++;
            $display("FAIL b2b_first got %h lat %0d expected %h lat 8", r1, t1, ref8(pa1, pb1, pc1));
        end
        checks++;
        if (r2 !== ref8(pa2, pb2, pc2) || t2 != 9) begin
            errors++;
            $display("FAIL b2b_second got %h gap %0d expected %h gap 9", r2, t2, ref8(pa2, pb2, pc2));
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [8:0] res;
        logic [7:0] x, y;
        logic       c;
        int lat;
        run8(8'h40, 8'h41, 1'b1, res, lat);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h99; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b done=%b cout=%b sum=%h expected all 0",
                     busy8, done8, cout8, sum8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy8 !== 1'b0 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_resume got busy=%b done=%b expected 0 0", busy8, done8);
            end
        end
        x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
        run8(x, y, c, res, lat);
        checks++;
        if (res !== ref8(x, y, c) || lat != 8) begin
            errors++;
            $display("FAIL midreset_next_add got %h lat %0d expected %h lat 8", res, lat, ref8(x, y, c));
        end
    endtask

    task automatic test_random;
        logic [8:0] res;
        logic [7:0] x, y;
        logic       c;
        int lat;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            run8(x, y, c, res, lat);
            checks++;
            if (res !== ref8(x, y, c) || lat != 8) begin
                errors++;
                $display("FAIL random_add a=%h b=%h cin=%b got %h lat %0d expected %h lat 8",
                         x, y, c, res, lat, ref8(x, y, c));
            end
        end
    endtask

    task automatic test_exhaustive_w4;
        logic [4:0] res;
        int lat;
        int base;
        base = doneCnt4;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) begin
                    run4(4'(x), 4'(y), 1'(c), res, lat);
                    checks++;
                    if (res !== ref4(x, y, c) || lat != 4) begin
                        errors++;
                        $display("FAIL w4_sweep a=%0d b=%0d cin=%0d got %h lat %0d expected %h lat 4",
                                 x, y, c, res, lat, ref4(x, y, c));
                    end
                end
        @(posedge clk); #1;
        checks++;
        if (doneCnt4 - base != 512) begin
            errors++;
            $display("FAIL w4_done_count got %0d expected 512", doneCnt4 - base);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_edge_values;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid_shift;
        test_random;
        test_exhaustive_w4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
